// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_mc
// Description : Hazard unit for the 5-stage RV32 pipeline. Resolves EX-stage
//               operand forwarding, load-use stalls, taken-branch flushes,
//               multi-cycle MDU occupancy of EX and data-memory wait states.
//               Also keeps a saturating count of fetch-stall cycles.
// Ports       :
//   clk, rst_n                 clock, asynchronous active-low reset
//   Rs1D, Rs2D                 source registers of the ID instruction
//   Rs1E, Rs2E, RdE            source/destination registers in EX
//   RdM, RdW                   destination registers in MEM / WB
//   RegWriteM, RegWriteW       register-write enables in MEM / WB
//   ResultSrcE                 result select of the EX instruction
//   PCSrcE                     branch/jump taken, resolved in EX
//   MduStartE                  EX instruction is an MDU op
//   MemReqM, MemReadyM         data-memory request / completion in MEM
//   ForwardAE, ForwardBE       operand selects: 00 RF, 01 WB, 10 MEM
//   StallF/D/E/M               hold PC / IF-ID / ID-EX / EX-MEM registers
//   FlushD/E/M/W               bubble IF-ID / ID-EX / EX-MEM / MEM-WB
//   MduBusy                    MDU FSM is in BUSY
//   StallCycles                saturating count of cycles with StallF=1
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
   parameter int                          ADDR_WIDTH       = 5,
   parameter int                          RESULT_SRC_WIDTH = 2,
   parameter logic [RESULT_SRC_WIDTH-1:0] LOAD_RESULT_SRC  = 2'b01,
   parameter int                          MDU_LATENCY      = 4,
   parameter int                          PERF_WIDTH       = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_WIDTH-1:0]       Rs1D,
   input  logic [ADDR_WIDTH-1:0]       Rs2D,
   input  logic [ADDR_WIDTH-1:0]       Rs1E,
   input  logic [ADDR_WIDTH-1:0]       Rs2E,
   input  logic [ADDR_WIDTH-1:0]       RdE,
   input  logic [ADDR_WIDTH-1:0]       RdM,
   input  logic [ADDR_WIDTH-1:0]       RdW,
   input  logic                        RegWriteM,
   input  logic                        RegWriteW,
   input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
   input  logic                        PCSrcE,
   input  logic                        MduStartE,
   input  logic                        MemReqM,
   input  logic                        MemReadyM,
   output logic [1:0]                  ForwardAE,
   output logic [1:0]                  ForwardBE,
   output logic                        StallF,
   output logic                        StallD,
   output logic                        StallE,
   output logic                        StallM,
   output logic                        FlushD,
   output logic                        FlushE,
   output logic                        FlushM,
   output logic                        FlushW,
   output logic                        MduBusy,
   output logic [PERF_WIDTH-1:0]       StallCycles
);

   localparam int                  c_cnt_w     = $clog2(MDU_LATENCY) + 1;
   // The first occupancy cycle is spent in IDLE, so BUSY loads LATENCY-2.
   localparam int                  c_start_int = (MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0;
   localparam logic [c_cnt_w-1:0]  c_cnt_start = c_cnt_w'(c_start_int);
   localparam bit                  c_mdu_multi = (MDU_LATENCY > 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_next;
   logic [PERF_WIDTH-1:0] r_stall_cycles;

   logic w_mem_stall;
   logic w_mdu_stall;
   logic w_lw_stall;
   logic w_stall_e;

   // ------------------------------------------------------------------------
   // Forwarding: MEM result is newer than WB, so it wins. x0 is never
   // forwarded since its value is hard-wired.
   // ------------------------------------------------------------------------
   always_comb begin
      ForwardAE = 2'b00;
      if ((Rs1E != '0) && RegWriteM && (Rs1E == RdM))
         ForwardAE = 2'b10;
      else if ((Rs1E != '0) && RegWriteW && (Rs1E == RdW))
         ForwardAE = 2'b01;

      ForwardBE = 2'b00;
      if ((Rs2E != '0) && RegWriteM && (Rs2E == RdM))
         ForwardBE = 2'b10;
      else if ((Rs2E != '0) && RegWriteW && (Rs2E == RdW))
         ForwardBE = 2'b01;
   end

   // A pending memory access freezes the whole pipe, including the MDU FSM.
   assign w_mem_stall = MemReqM & ~MemReadyM;

   // ------------------------------------------------------------------------
   // MDU occupancy FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_mdu_stall  = 1'b0;
      if (!w_mem_stall) begin
         case (r_state)
            IDLE: begin
               if (MduStartE && c_mdu_multi) begin
                  w_mdu_stall  = 1'b1;
                  w_cnt_next   = c_cnt_start;
                  w_state_next = BUSY;
               end
            end
            BUSY: begin
               if (r_cnt != '0) begin
                  w_mdu_stall = 1'b1;
                  w_cnt_next  = r_cnt - c_cnt_w'(1);
               end else begin
                  // Final occupancy cycle: the op leaves EX this cycle.
                  w_state_next = IDLE;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   assign MduBusy = (r_state == BUSY);

   // Load-use only matters when the pipe is otherwise free to advance.
   assign w_lw_stall = ~w_mem_stall & ~w_mdu_stall
                     & (ResultSrcE == LOAD_RESULT_SRC)
                     & (RdE != '0)
                     & ((Rs1D == RdE) | (Rs2D == RdE));

   assign w_stall_e = w_mem_stall | w_mdu_stall;

   assign StallF = w_stall_e | w_lw_stall;
   assign StallD = w_stall_e | w_lw_stall;
   assign StallE = w_stall_e;
   assign StallM = w_mem_stall;
   assign FlushW = w_mem_stall;
   assign FlushM = w_mdu_stall;
   // A frozen EX must not be flushed; a held branch flushes on release.
   assign FlushE = ~w_stall_e & (w_lw_stall | PCSrcE);
   assign FlushD = ~w_stall_e & PCSrcE;

   // ------------------------------------------------------------------------
   // Saturating stall-cycle counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (StallF && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + PERF_WIDTH'(1);
      end
   end

   assign StallCycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_mc
// Description : Directed self-checking bench for hazard_unit_mc. A default
//               instance, a PERF_WIDTH=4 instance and an MDU_LATENCY=1
//               instance share one set of stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, MduStartE, MemReqM, MemReadyM;

   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduBusy;
   logic [15:0] StallCycles;

   logic [1:0]  s_fa, s_fb;
   logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fm, s_fw, s_busy;
   logic [3:0]  s_cycles;

   logic [1:0]  l_fa, l_fb;
   logic        l_sf, l_sd, l_se, l_sm, l_fd, l_fe, l_fm, l_fw, l_busy;
   logic [15:0] l_cycles;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hazard_unit_mc dut (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .MduBusy(MduBusy), .StallCycles(StallCycles)
   );

   hazard_unit_mc #(.PERF_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ForwardAE(s_fa), .ForwardBE(s_fb),
      .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
      .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm), .FlushW(s_fw),
      .MduBusy(s_busy), .StallCycles(s_cycles)
   );

   hazard_unit_mc #(.MDU_LATENCY(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ForwardAE(l_fa), .ForwardBE(l_fb),
      .StallF(l_sf), .StallD(l_sd), .StallE(l_se), .StallM(l_sm),
      .FlushD(l_fd), .FlushE(l_fe), .FlushM(l_fm), .FlushW(l_fw),
      .MduBusy(l_busy), .StallCycles(l_cycles)
   );

   task automatic clear_inputs();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = '0; PCSrcE = 0;
      MduStartE = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   // Advance one clock; leaves time at posedge+1 so registered outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [14:0] outs;
      do_reset();
      outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
              FlushD, FlushE, FlushM, FlushW, MduBusy};
      tests++;
      if (outs !== 15'd0) begin
         fails++; $display("FAIL reset_outputs: got %b expected %b", outs, 15'd0);
      end
      tests++;
      if (StallCycles !== 16'd0) begin
         fails++; $display("FAIL reset_stallcycles: got %0d expected 0", StallCycles);
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      RdM = 5'd5; RdW = 5'd5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5'd5; Rs2E = 5'd5;
      #1;
      tests++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
         fails++; $display("FAIL fwd_mem_priority: got A=%b B=%b expected 10/10", ForwardAE, ForwardBE);
      end
      RegWriteM = 0;
      #1;
      tests++;
      if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
         fails++; $display("FAIL fwd_wb: got A=%b B=%b expected 01/01", ForwardAE, ForwardBE);
      end
      Rs1E = 5'd0;
      #1;
      tests++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
         fails++; $display("FAIL fwd_x0: got A=%b B=%b expected 00/01", ForwardAE, ForwardBE);
      end
      // MEM holds a different register, WB matches: WB wins for A, MEM for B.
      Rs1E = 5'd9; Rs2E = 5'd12; RdM = 5'd12; RdW = 5'd9; RegWriteM = 1;
      #1;
      tests++;
      if (ForwardAE !== 2'b01 || ForwardBE !== 2'b10) begin
         fails++; $display("FAIL fwd_split: got A=%b B=%b expected 01/10", ForwardAE, ForwardBE);
      end
   endtask

   task automatic test_load_use();
      logic [3:0] got;
      do_reset();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      got = {StallF, StallD, FlushE, StallE};
      tests++;
      if (got !== 4'b1110) begin
         fails++; $display("FAIL lw_rs2: got SF,SD,FE,SE=%b expected 1110", got);
      end
      step();
      clear_inputs();
      #1;
      tests++;
      if (StallCycles !== 16'd1 || StallF !== 1'b0) begin
         fails++; $display("FAIL lw_count: got cycles=%0d StallF=%b expected 1/0", StallCycles, StallF);
      end
      ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
      #1;
      tests++;
      if (StallF !== 1'b1 || FlushE !== 1'b1) begin
         fails++; $display("FAIL lw_rs1: got StallF=%b FlushE=%b expected 1/1", StallF, FlushE);
      end
      RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      tests++;
      if (StallF !== 1'b0 || FlushE !== 1'b0) begin
         fails++; $display("FAIL lw_x0: got StallF=%b FlushE=%b expected 0/0", StallF, FlushE);
      end
   endtask

   task automatic test_mdu();
      logic [5:0] got, exp;
      int ph;
      do_reset();
      MduStartE = 1;
      #1;
      for (int c = 1; c <= 8; c++) begin
         ph = ((c - 1) % 4) + 1;
         exp = {(ph <= 3), (ph <= 3), (ph <= 3), (ph <= 3), 1'b0, (ph >= 2)};
         got = {StallF, StallD, StallE, FlushM, StallM, MduBusy};
         tests++;
         if (got !== exp) begin
            fails++; $display("FAIL mdu_cycle%0d: got %b expected %b", c, got, exp);
         end
         tests++;
         if (l_sf !== 1'b0 || l_busy !== 1'b0) begin
            fails++; $display("FAIL mdu_lat1_cycle%0d: got StallF=%b busy=%b expected 0/0", c, l_sf, l_busy);
         end
         step();
      end
      MduStartE = 0;
      #1;
      tests++;
      if (StallCycles !== 16'd6 || MduBusy !== 1'b0) begin
         fails++; $display("FAIL mdu_done: got cycles=%0d busy=%b expected 6/0", StallCycles, MduBusy);
      end
   endtask

   task automatic test_mem_wait();
      logic [6:0] got;
      do_reset();
      MduStartE = 1;
      step();
      step();
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         got = {StallF, StallD, StallE, StallM, FlushW, FlushM, MduBusy};
         tests++;
         if (got !== 7'b1111101) begin
            fails++; $display("FAIL memwait_frozen%0d: got %b expected 1111101", i, got);
         end
         step();
      end
      MemReadyM = 1;
      #1;
      got = {StallF, StallD, StallE, StallM, FlushW, FlushM, MduBusy};
      tests++;
      if (got !== 7'b1110011) begin
         fails++; $display("FAIL memwait_resume: got %b expected 1110011", got);
      end
      step();
      MemReqM = 0; MemReadyM = 0;
      #1;
      got = {StallF, StallD, StallE, StallM, FlushW, FlushM, MduBusy};
      tests++;
      if (got !== 7'b0000001) begin
         fails++; $display("FAIL memwait_release: got %b expected 0000001", got);
      end
      step();
      MduStartE = 0;
      #1;
      tests++;
      if (MduBusy !== 1'b0 || StallCycles !== 16'd5) begin
         fails++; $display("FAIL memwait_done: got busy=%b cycles=%0d expected 0/5", MduBusy, StallCycles);
      end
   endtask

   task automatic test_branch();
      logic [4:0] got;
      do_reset();
      PCSrcE = 1;
      #1;
      got = {FlushD, FlushE, StallF, StallE, StallM};
      tests++;
      if (got !== 5'b11000) begin
         fails++; $display("FAIL branch_plain: got FD,FE,SF,SE,SM=%b expected 11000", got);
      end
      step();
      MemReqM = 1; MemReadyM = 0;
      #1;
      got = {FlushD, FlushE, StallF, StallM, FlushW};
      tests++;
      if (got !== 5'b00111) begin
         fails++; $display("FAIL branch_held: got FD,FE,SF,SM,FW=%b expected 00111", got);
      end
      step();
      MemReadyM = 1;
      #1;
      got = {FlushD, FlushE, StallF, StallM, FlushW};
      tests++;
      if (got !== 5'b11000) begin
         fails++; $display("FAIL branch_release: got FD,FE,SF,SM,FW=%b expected 11000", got);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      MduStartE = 1;
      step();
      step();
      tests++;
      if (MduBusy !== 1'b1 || StallCycles !== 16'd2) begin
         fails++; $display("FAIL midbusy_pre: got busy=%b cycles=%0d expected 1/2", MduBusy, StallCycles);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (MduBusy !== 1'b0 || StallCycles !== 16'd0 || s_cycles !== 4'd0) begin
         fails++; $display("FAIL midbusy_async: got busy=%b cycles=%0d sat=%0d expected 0/0/0",
                           MduBusy, StallCycles, s_cycles);
      end
      MduStartE = 0;
      step();
      rst_n = 1'b1;
      step();
      tests++;
      if (StallF !== 1'b0 || MduBusy !== 1'b0) begin
         fails++; $display("FAIL midbusy_after: got StallF=%b busy=%b expected 0/0", StallF, MduBusy);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
      for (int i = 0; i < 20; i++) step();
      tests++;
      if (s_cycles !== 4'd15 || StallCycles !== 16'd20) begin
         fails++; $display("FAIL sat_count: got sat=%0d full=%0d expected 15/20", s_cycles, StallCycles);
      end
      step();
      tests++;
      if (s_cycles !== 4'd15) begin
         fails++; $display("FAIL sat_hold: got %0d expected 15", s_cycles);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_mdu();
      test_mem_wait();
      test_branch();
      test_reset_mid_busy();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
